// File: rtl/serial_decoder_pkg.sv
// rtl/serial_decoder_pkg.sv - shared frame layout, defaults and FSM state type for the serial codec
package serial_decoder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int GAP_SLOTS      = 1;
  localparam int DEF_FRAME_LEN  = DEF_DATA_WIDTH + GAP_SLOTS;

  // Slot 0 of every frame is the gap (load strobe); data follows LSB first.
  localparam int GAP_SLOT_INDEX  = 0;
  localparam int FIRST_DATA_SLOT = GAP_SLOT_INDEX + GAP_SLOTS;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/decoder_holding_reg.sv
// rtl/decoder_holding_reg.sv - one-deep valid/ready output buffer with overrun pulse
module decoder_holding_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun
);

  logic transfer;
  logic accept_new;

  assign transfer   = valid & ready;
  // A new word fits if the slot is empty or is being drained on this edge.
  assign accept_new = load & (~valid | transfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & ~accept_new;
      if (accept_new) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (transfer) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_decoder.sv
// rtl/serial_decoder.sv - frame-aligned serial-to-parallel decoder with handshake output
module serial_decoder
  import serial_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  serialIn,
  input  logic                  frameSync,
  input  logic                  messageReady,
  output logic [DATA_WIDTH-1:0] message,
  output logic                  messageValid,
  output logic                  locked,
  output logic                  syncError,
  output logic                  overrun
);

  localparam int CNT_W    = cnt_width(DATA_WIDTH);
  localparam int LAST_IDX = FRAME_LEN - GAP_SLOTS - 1;

  dec_state_t             state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  word_with_bit;
  logic                   word_done;
  logic                   sync_err_d;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      syncError <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      syncError <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    word_done     = 1'b0;
    sync_err_d    = 1'b0;
    word_with_bit = shift_q;
    word_with_bit[bit_cnt_q] = serialIn;

    case (state_q)
      HUNT: begin
        if (frameSync) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // An early strobe restarts the frame: its slot is a gap, not data.
        if (frameSync) begin
          sync_err_d = 1'b1;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end else if (bit_cnt_q == CNT_W'(LAST_IDX)) begin
          word_done = 1'b1;
          state_d   = GAP;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          shift_d   = word_with_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (frameSync) begin
          state_d = SHIFT;
        end else begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
        end
      end
      default: begin
        state_d   = HUNT;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign locked = (state_q != HUNT);

  decoder_holding_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk       (clock),
    .rst_n     (resetN),
    .load      (word_done),
    .load_data (word_with_bit),
    .ready     (messageReady),
    .data      (message),
    .valid     (messageValid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_decoder.sv
// tb/tb_serial_decoder.sv - scoreboard bench for serial_decoder
module tb_serial_decoder;

  logic       clock = 1'b0;
  logic       resetN;
  logic       serialIn;
  logic       frameSync;
  logic       messageReady;
  logic [7:0] message;
  logic       messageValid;
  logic       locked;
  logic       syncError;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         sync_cnt = 0;
  int         ovr_cnt = 0;
  int         valid_cycles = 0;
  logic [7:0] exp_q[$];
  int         xfer_cyc[$];
  logic [7:0] mon_exp;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_decoder dut (
    .clock        (clock),
    .resetN       (resetN),
    .serialIn     (serialIn),
    .frameSync    (frameSync),
    .messageReady (messageReady),
    .message      (message),
    .messageValid (messageValid),
    .locked       (locked),
    .syncError    (syncError),
    .overrun      (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next edge whenever valid and ready are both high.
  always @(negedge clock) begin
    if (resetN === 1'b1) begin
      if (syncError) sync_cnt++;
      if (overrun) ovr_cnt++;
      if (messageValid) valid_cycles++;
      if (messageValid && messageReady) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", message);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 32'(message), 32'(mon_exp));
        end
      end
    end
  end

  task automatic slot(input logic fs, input logic b);
    frameSync = fs;
    serialIn  = b;
    @(posedge clock);
    #1;
  endtask

  task automatic data_bits(input logic [7:0] w, input logic last_ready);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) messageReady = last_ready;
      slot(1'b0, w[i]);
    end
  endtask

  task automatic frame(input logic [7:0] w);
    slot(1'b1, 1'b0);
    data_bits(w, messageReady);
  endtask

  initial begin
    logic [7:0] words[3];
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    resetN = 1'b0; serialIn = 1'b0; frameSync = 1'b0; messageReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_message", 32'(message), 32'h0);
    check("rst_valid", 32'(messageValid), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_syncerr", 32'(syncError), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    // Lock and single word
    resetN = 1'b1;
    messageReady = 1'b1;
    exp_q.push_back(8'h4D);
    frame(8'h4D);
    check("msg_4d", 32'(message), 32'h4D);
    check("valid_4d", 32'(messageValid), 32'h1);
    check("locked_4d", 32'(locked), 32'h1);

    // Back-to-back frames
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      frame(words[i]);
    end
    slot(1'b1, 1'b0);
    check("b2b_valid_cycles", valid_cycles, 4);
    check("b2b_xfers", xfer_cyc.size(), 4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", xfer_cyc[i] - xfer_cyc[i-1], 9);
    check("b2b_syncerr", sync_cnt, 0);
    check("b2b_overrun", ovr_cnt, 0);

    // Backpressure and overrun
    messageReady = 1'b0;
    data_bits(8'h11, 1'b0);
    slot(1'b1, 1'b0);
    data_bits(8'h22, 1'b0);
    check("bp_message", 32'(message), 32'h11);
    check("bp_valid", 32'(messageValid), 32'h1);
    check("bp_overrun_pulse", 32'(overrun), 32'h1);
    exp_q.push_back(8'h11);
    messageReady = 1'b1;
    slot(1'b1, 1'b0);
    check("bp_drained", 32'(messageValid), 32'h0);
    check("bp_overrun_cnt", ovr_cnt, 1);

    // Accept and complete on the same edge
    messageReady = 1'b0;
    data_bits(8'h11, 1'b0);
    slot(1'b1, 1'b0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    data_bits(8'h22, 1'b1);
    check("sim_message", 32'(message), 32'h22);
    check("sim_valid", 32'(messageValid), 32'h1);
    check("sim_no_overrun", 32'(overrun), 32'h0);
    slot(1'b1, 1'b0);
    check("sim_overrun_cnt", ovr_cnt, 1);

    // Early frameSync at data slot 4
    for (int i = 0; i < 4; i++) slot(1'b0, 1'b1);
    slot(1'b1, 1'b0);
    check("early_sync_pulse", 32'(syncError), 32'h1);
    check("early_sync_locked", 32'(locked), 32'h1);
    exp_q.push_back(8'h5A);
    data_bits(8'h5A, 1'b1);
    check("early_sync_word", 32'(message), 32'h5A);
    slot(1'b1, 1'b0);
    check("early_sync_cnt", sync_cnt, 1);

    // Missing gap strobe
    exp_q.push_back(8'h81);
    data_bits(8'h81, 1'b1);
    slot(1'b0, 1'b0);
    check("gap_miss_pulse", 32'(syncError), 32'h1);
    check("gap_miss_locked", 32'(locked), 32'h0);
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b1);
    check("hunt_locked", 32'(locked), 32'h0);
    exp_q.push_back(8'hC3);
    frame(8'hC3);
    check("relock_word", 32'(message), 32'hC3);
    check("relock_locked", 32'(locked), 32'h1);
    slot(1'b1, 1'b0);
    check("gap_miss_cnt", sync_cnt, 2);

    // Async reset mid-frame with a word held
    messageReady = 1'b0;
    data_bits(8'h4D, 1'b0);
    check("held_4d", 32'(message), 32'h4D);
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b1);
    slot(1'b0, 1'b0);
    slot(1'b0, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    check("arst_message", 32'(message), 32'h0);
    check("arst_valid", 32'(messageValid), 32'h0);
    check("arst_locked", 32'(locked), 32'h0);
    check("arst_syncerr", 32'(syncError), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    messageReady = 1'b1;
    slot(1'b0, 1'b1);
    check("arst_hunt", 32'(locked), 32'h0);
    exp_q.push_back(8'h96);
    frame(8'h96);
    check("arst_relock_word", 32'(message), 32'h96);
    slot(1'b1, 1'b0);
    frameSync = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    check("final_queue_empty", exp_q.size(), 0);
    check("final_xfers", xfer_cyc.size(), 11);
    check("final_overrun_cnt", ovr_cnt, 1);
    check("final_sync_cnt", sync_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
